// File: rtl/sram_hist_arbiter.sv
// Arbiter and cycle sequencer for the external histogram SRAM: read-modify-write
// increments, word reads and a bulk clear sweep share one async SRAM port.
//
// state | meaning
// IDLE  | grant point; SRAM left in read-idle (oe_n low, bus released)
// RADR  | address + oe_n asserted, WAIT_CYC access cycles counted down
// RLAT  | read word latched (rd_valid for reads, incremented word for bins)
// WSET  | oe_n high, write data driven, address held
// WPUL  | we_n low
// WHLD  | we_n high, address and data still driven
module sram_hist_arbiter #(
    parameter int AW       = 20,
    parameter int DW       = 16,
    parameter int WAIT_CYC = 1,
    parameter int CLR_LAST = 1023
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          inc_req,
    input  logic [AW-1:0] inc_adrs,
    output logic          inc_ack,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_adrs,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          sat_flag,
    output logic [15:0]   drop_cnt,
    output logic [AW-1:0] sram_adrs,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RADR = 3'd1;
    localparam logic [2:0] RLAT = 3'd2;
    localparam logic [2:0] WSET = 3'd3;
    localparam logic [2:0] WPUL = 3'd4;
    localparam logic [2:0] WHLD = 3'd5;

    localparam logic [3:0]    WAIT_LD    = 4'(WAIT_CYC - 1);
    localparam logic [AW-1:0] CLR_LAST_A = AW'(CLR_LAST);
    localparam logic [DW-1:0] BIN_MAX    = {DW{1'b1}};

    logic [2:0]    state;
    logic [3:0]    wait_cnt;
    logic          op_rd;
    logic          clr_run;
    logic          clr_pend;
    logic          pend_v;
    logic [AW-1:0] pend_adrs;

    logic idle, clr_gnt, inc_gnt, rd_gnt, inc_cap, inc_drop, clr_done;

    always_comb begin
        idle     = (state == IDLE);
        clr_gnt  = idle & (clr_start | clr_pend);
        inc_gnt  = idle & ~clr_gnt & pend_v;
        rd_gnt   = idle & ~clr_gnt & ~pend_v & rd_req;
        inc_cap  = inc_req & (~pend_v | inc_gnt);
        inc_drop = inc_req & pend_v & ~inc_gnt;
        clr_done = (state == WHLD) & clr_run & (sram_adrs == CLR_LAST_A);
    end

    assign clr_busy = clr_pend | clr_run;

    // Pending increment buffer, clear latch and drop counter
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend_v    <= 1'b0;
            pend_adrs <= '0;
            inc_ack   <= 1'b0;
            drop_cnt  <= '0;
            clr_pend  <= 1'b0;
        end else begin
            inc_ack <= inc_cap;
            if (inc_cap) begin
                pend_v    <= 1'b1;
                pend_adrs <= inc_adrs;
            end else if (inc_gnt) begin
                pend_v <= 1'b0;
            end
            if (inc_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (clr_gnt)
                clr_pend <= 1'b0;
            else if (clr_start)
                clr_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            op_rd      <= 1'b0;
            clr_run    <= 1'b0;
            sat_flag   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            sram_adrs  <= '0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_gnt) begin
                        state      <= WSET;
                        clr_run    <= 1'b1;
                        sat_flag   <= 1'b0;
                        sram_adrs  <= '0;
                        sram_dq_o  <= '0;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b1;
                    end else if (inc_gnt || rd_gnt) begin
                        state     <= RADR;
                        op_rd     <= rd_gnt;
                        sram_adrs <= inc_gnt ? pend_adrs : rd_adrs;
                        sram_oe_n <= 1'b0;
                        wait_cnt  <= WAIT_LD;
                    end
                end
                RADR: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RLAT;
                        if (op_rd) begin
                            rd_data  <= sram_dq_i;
                            rd_valid <= 1'b1;
                        end else if (sram_dq_i == BIN_MAX) begin
                            // bins saturate instead of wrapping
                            sram_dq_o <= BIN_MAX;
                            sat_flag  <= 1'b1;
                        end else begin
                            sram_dq_o <= sram_dq_i + DW'(1);
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RLAT: begin
                    if (op_rd) begin
                        state <= IDLE;
                    end else begin
                        state      <= WSET;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b1;
                    end
                end
                WSET: begin
                    state     <= WPUL;
                    sram_we_n <= 1'b0;
                end
                WPUL: begin
                    state     <= WHLD;
                    sram_we_n <= 1'b1;
                end
                WHLD: begin
                    if (clr_run && !clr_done) begin
                        state     <= WSET;
                        sram_adrs <= sram_adrs + AW'(1);
                    end else begin
                        state      <= IDLE;
                        clr_run    <= 1'b0;
                        sram_dq_oe <= 1'b0;
                        sram_oe_n  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_hist_arbiter.sv
// Directed bench for sram_hist_arbiter with a behavioural SRAM model and
// protocol monitors on the SRAM control pins.
module tb_sram_hist_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          inc_req = 1'b0;
    logic [AW-1:0] inc_adrs = '0;
    logic          inc_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_adrs = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          sat_flag;
    logic [15:0]   drop_cnt;
    logic [AW-1:0] sram_adrs;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i;

    sram_hist_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(1), .CLR_LAST(1023)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .inc_req(inc_req), .inc_adrs(inc_adrs), .inc_ack(inc_ack),
        .rd_req(rd_req), .rd_adrs(rd_adrs), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_start(clr_start), .clr_busy(clr_busy), .sat_flag(sat_flag), .drop_cnt(drop_cnt),
        .sram_adrs(sram_adrs), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
    );

    always #4 CLK = ~CLK;

    logic [15:0] mem [0:2047];
    logic        pre_en = 1'b0;
    logic [10:0] pre_adr = '0;
    logic [15:0] pre_val = '0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    int          we_bad = 0;
    int          we_run = 0;
    int          ack_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    assign sram_dq_i = !sram_oe_n ? mem[sram_adrs[10:0]] : 16'hDEAD;

    always @(posedge CLK) begin
        if (pre_en) mem[pre_adr] <= pre_val;
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_adrs[10:0]] <= sram_dq_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if (sram_dq_oe && !sram_oe_n) overlap_cnt <= overlap_cnt + 1;
        if (inc_ack) ack_cnt <= ack_cnt + 1;
        if (!sram_we_n) begin
            we_run <= we_run + 1;
        end else begin
            if (we_run != 0 && we_run != 1) we_bad <= we_bad + 1;
            we_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [10:0] adr, input logic [15:0] val);
        pre_en = 1'b1; pre_adr = adr; pre_val = val;
        tick(1);
        pre_en = 1'b0;
    endtask

    task automatic pulse_inc(input logic [AW-1:0] adr);
        inc_req = 1'b1; inc_adrs = adr;
        tick(1);
        inc_req = 1'b0;
    endtask

    initial begin
        int n, a0, w0, pulses;

        tick(3);
        chk("rst_adrs", sram_adrs, 0);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_dq_o", sram_dq_o, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_inc_ack", inc_ack, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_drop", drop_cnt, 0);
        RSTN = 1'b1;
        tick(2);

        // full clear sweep
        preload(11'd1024, 16'hA5A5);
        preload(11'd700, 16'h1234);
        clr_start = 1'b1;
        tick(1);
        clr_start = 1'b0;
        n = 0;
        while (clr_busy && n < 5000) begin
            tick(1);
            n++;
        end
        chk("clr_busy_cycles", n, 3072);
        chk("clr_mem0", mem[0], 0);
        chk("clr_mem700", mem[700], 0);
        chk("clr_mem1023", mem[1023], 0);
        chk("clr_mem1024_untouched", mem[1024], 16'hA5A5);
        chk("clr_write_count", wr_cnt, 1024);

        preload(11'd5, 16'd7);
        preload(11'd9, 16'hFFFF);
        preload(11'd1, 16'd100);
        preload(11'd2, 16'd200);
        preload(11'd3, 16'd300);
        preload(11'd7, 16'd20);
        preload(11'd20, 16'd50);

        // single increment
        a0 = ack_cnt;
        pulse_inc(20'd5);
        chk("inc_ack_next", inc_ack, 1);
        tick(1);
        chk("inc_ack_one_cycle", inc_ack, 0);
        tick(10);
        chk("inc_bin5", mem[5], 8);
        chk("inc_ack_count", ack_cnt - a0, 1);

        // saturating bin
        pulse_inc(20'd9);
        tick(10);
        chk("sat_bin9", mem[9], 16'hFFFF);
        chk("sat_flag_set", sat_flag, 1);

        // back-to-back requests overflow the one-entry buffer
        a0 = ack_cnt;
        inc_req = 1'b1; inc_adrs = 20'd1;
        tick(1);
        inc_adrs = 20'd2;
        tick(1);
        inc_adrs = 20'd3;
        tick(1);
        inc_req = 1'b0;
        tick(20);
        chk("b2b_bin1", mem[1], 101);
        chk("b2b_bin2", mem[2], 201);
        chk("b2b_bin3_dropped", mem[3], 300);
        chk("b2b_drop_cnt", drop_cnt, 1);
        chk("b2b_ack_count", ack_cnt - a0, 2);

        // read waits behind a pending increment
        pulse_inc(20'd7);
        rd_req = 1'b1; rd_adrs = 20'd5;
        n = 0;
        while (!rd_valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("rd_after_inc_latency", n, 8);
        chk("rd_after_inc_data", rd_data, 8);
        chk("rd_inc_done_first", mem[7], 21);
        tick(1);
        rd_req = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick(1);
            if (rd_valid) pulses++;
        end
        chk("rd_no_repeat", pulses, 0);

        // plain read from idle
        rd_req = 1'b1; rd_adrs = 20'd1;
        n = 0;
        while (!rd_valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("rd_idle_latency", n, 2);
        chk("rd_idle_data", rd_data, 101);
        tick(1);
        rd_req = 1'b0;
        tick(3);

        // second sweep clears sat_flag, then reset abandons it
        clr_start = 1'b1;
        tick(1);
        clr_start = 1'b0;
        tick(5);
        chk("clr2_sat_cleared", sat_flag, 0);
        chk("clr2_busy", clr_busy, 1);
        chk("clr2_drop_kept", drop_cnt, 1);
        RSTN = 1'b0;
        #1;
        chk("rst_sweep_busy", clr_busy, 0);
        chk("rst_sweep_we_n", sram_we_n, 1);
        chk("rst_sweep_dq_oe", sram_dq_oe, 0);
        chk("rst_sweep_oe_n", sram_oe_n, 1);
        chk("rst_sweep_adrs", sram_adrs, 0);
        w0 = wr_cnt;
        tick(1);
        RSTN = 1'b1;
        tick(30);
        chk("rst_sweep_no_writes", wr_cnt - w0, 0);
        chk("rst_sweep_busy_after", clr_busy, 0);
        chk("rst_drop_cleared", drop_cnt, 0);

        // reset during the write pulse of an increment
        pulse_inc(20'd20);
        n = 0;
        while (sram_we_n && n < 50) begin
            tick(1);
            n++;
        end
        chk("wpul_reached", n < 50, 1);
        RSTN = 1'b0;
        #1;
        chk("rst_wpul_we_n", sram_we_n, 1);
        chk("rst_wpul_dq_oe", sram_dq_oe, 0);
        w0 = wr_cnt;
        tick(1);
        RSTN = 1'b1;
        tick(20);
        chk("rst_wpul_bin_unchanged", mem[20], 50);
        chk("rst_wpul_no_writes", wr_cnt - w0, 0);

        pulse_inc(20'd20);
        tick(10);
        chk("resume_inc_bin20", mem[20], 51);

        chk("oe_dq_overlap", overlap_cnt, 0);
        chk("we_pulse_width", we_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
